// File: rtl/ber_sweep_monitor.sv
// Noise-sweep BER monitor: steps sigma_scale through a programmed table and
// accumulates per-phase I/Q sign-decision errors into a readable result bank.
module ber_sweep_monitor #(
    parameter int DWIDTH    = 9,
    parameter int SNR_WIDTH = 11,
    parameter int N_PHASES  = 4,
    parameter int DLY_DEPTH = 16,
    parameter int LEN_W     = 16,
    parameter int CNT_W     = 24,
    localparam int PH_W     = $clog2(N_PHASES),
    localparam int LAT_W    = $clog2(DLY_DEPTH),
    localparam int SUM_W    = CNT_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tbl_we,
    input  logic [PH_W-1:0]      tbl_addr,
    input  logic [SNR_WIDTH-1:0] tbl_sigma,
    input  logic [LEN_W-1:0]     settle_len,
    input  logic [LEN_W-1:0]     dwell_len,
    input  logic [LAT_W-1:0]     lat,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [DWIDTH-1:0]    tx_I,
    input  logic [DWIDTH-1:0]    tx_Q,
    input  logic [DWIDTH-1:0]    rx_I,
    input  logic [DWIDTH-1:0]    rx_Q,
    output logic [SNR_WIDTH-1:0] sigma_scale,
    output logic                 busy,
    output logic                 done,
    output logic [PH_W-1:0]      phase,
    input  logic [PH_W-1:0]      res_addr,
    output logic [CNT_W-1:0]     res_err,
    output logic [CNT_W-1:0]     res_sym
);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_NEXT, S_DONE} state_t;

    state_t               state_q;
    logic [PH_W-1:0]      phase_q;
    logic [SNR_WIDTH-1:0] sigma_q;
    logic                 busy_q;
    logic                 done_q;
    logic [LEN_W-1:0]     settle_len_q;
    logic [LEN_W-1:0]     dwell_len_q;
    logic [LEN_W-1:0]     len_cnt_q;
    logic [LAT_W-1:0]     lat_q;
    logic [CNT_W-1:0]     err_q, sym_q;
    logic [CNT_W-1:0]     res_err_q, res_sym_q;
    logic [SNR_WIDTH-1:0] tbl_q      [N_PHASES];
    logic [CNT_W-1:0]     bank_err_q [N_PHASES];
    logic [CNT_W-1:0]     bank_sym_q [N_PHASES];
    // Entry k holds the {I,Q} tx sign bits from k+1 valid samples ago.
    logic [1:0]           dly_q      [DLY_DEPTH-1];

    logic [1:0]       tx_sign_now, tx_sign_tap;
    logic             e_i, e_q;
    logic [SUM_W-1:0] err_sum;
    logic [CNT_W-1:0] err_d, sym_d;
    logic             unused_low_bits;

    assign unused_low_bits = ^{tx_I[DWIDTH-2:0], tx_Q[DWIDTH-2:0],
                               rx_I[DWIDTH-2:0], rx_Q[DWIDTH-2:0]};

    always_comb begin
        tx_sign_now = {tx_I[DWIDTH-1], tx_Q[DWIDTH-1]};
        tx_sign_tap = (lat_q == '0) ? tx_sign_now : dly_q[lat_q - LAT_W'(1)];
        e_i         = tx_sign_tap[1] ^ rx_I[DWIDTH-1];
        e_q         = tx_sign_tap[0] ^ rx_Q[DWIDTH-1];
        // One extra bit catches the carry so the counter clamps instead of wrapping.
        err_sum     = {1'b0, err_q} + SUM_W'(e_i) + SUM_W'(e_q);
        err_d       = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        sym_d       = (&sym_q) ? sym_q : sym_q + CNT_W'(1);
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order within the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            sigma_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            settle_len_q <= '0;
            dwell_len_q  <= '0;
            len_cnt_q    <= '0;
            lat_q        <= '0;
            err_q        <= '0;
            sym_q        <= '0;
            res_err_q    <= '0;
            res_sym_q    <= '0;
            // NOTE: the table, result bank and delay line are cleared explicitly so
            // a reset mid-sweep leaves no stale results readable.
            for (int i = 0; i < N_PHASES; i++) begin
                tbl_q[i]      <= '0;
                bank_err_q[i] <= '0;
                bank_sym_q[i] <= '0;
            end
            for (int i = 0; i < DLY_DEPTH - 1; i++) dly_q[i] <= '0;
        end else begin
            if (in_valid) begin
                dly_q[0] <= tx_sign_now;
                for (int i = 1; i < DLY_DEPTH - 1; i++) dly_q[i] <= dly_q[i-1];
            end

            res_err_q <= bank_err_q[res_addr];
            res_sym_q <= bank_sym_q[res_addr];

            if (tbl_we && !busy_q) tbl_q[tbl_addr] <= tbl_sigma;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_SETTLE;
                        phase_q      <= '0;
                        sigma_q      <= tbl_q[0];
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        err_q        <= '0;
                        sym_q        <= '0;
                        len_cnt_q    <= '0;
                        settle_len_q <= (settle_len == '0) ? LEN_W'(1) : settle_len;
                        dwell_len_q  <= (dwell_len == '0) ? LEN_W'(1) : dwell_len;
                        lat_q        <= lat;
                    end
                end
                S_SETTLE: begin
                    if (len_cnt_q == settle_len_q - LEN_W'(1)) begin
                        len_cnt_q <= '0;
                        state_q   <= S_MEASURE;
                    end else begin
                        len_cnt_q <= len_cnt_q + LEN_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (in_valid) begin
                        err_q <= err_d;
                        sym_q <= sym_d;
                        if (len_cnt_q == dwell_len_q - LEN_W'(1)) begin
                            len_cnt_q <= '0;
                            state_q   <= S_NEXT;
                        end else begin
                            len_cnt_q <= len_cnt_q + LEN_W'(1);
                        end
                    end
                end
                S_NEXT: begin
                    bank_err_q[phase_q] <= err_q;
                    bank_sym_q[phase_q] <= sym_q;
                    err_q               <= '0;
                    sym_q               <= '0;
                    if (phase_q == PH_W'(N_PHASES - 1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sigma_q <= '0;
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                        sigma_q <= tbl_q[phase_q + PH_W'(1)];
                        state_q <= S_SETTLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sigma_scale = sigma_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign phase       = phase_q;
    assign res_err     = res_err_q;
    assign res_sym     = res_sym_q;

endmodule
